// File: rtl/coram_mem_arbiter_if.sv
// Bus between the CoRAM requesters, the arbiter and the single-port memory.
// The master side is the requester/memory environment; the slave side is the arbiter.
interface coram_mem_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W_A   = 7,
    parameter int unsigned W_D   = 32
);
    logic [N_REQ-1:0]     REQ;
    logic [N_REQ-1:0]     WE_IN;
    logic [N_REQ*W_A-1:0] ADDR_IN;
    logic [N_REQ*W_D-1:0] D_IN;
    logic [N_REQ-1:0]     ACK;
    logic [N_REQ-1:0]     RVALID;
    logic [W_D-1:0]       RDATA;
    logic [W_A-1:0]       MEM_ADDR;
    logic [W_D-1:0]       MEM_D;
    logic                 MEM_WE;
    logic [W_D-1:0]       MEM_Q;
    logic                 BUSY;

    modport master (
        output REQ, WE_IN, ADDR_IN, D_IN, MEM_Q,
        input  ACK, RVALID, RDATA, MEM_ADDR, MEM_D, MEM_WE, BUSY
    );

    modport slave (
        input  REQ, WE_IN, ADDR_IN, D_IN, MEM_Q,
        output ACK, RVALID, RDATA, MEM_ADDR, MEM_D, MEM_WE, BUSY
    );
endinterface

// File: rtl/coram_mem_arbiter.sv
// Round-robin arbiter with bounded bursts in front of one single-port CoRAM memory.
// Grants are combinational; the memory port and read-return strobes are registered.
module coram_mem_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned W_A       = 7,
    parameter int unsigned W_D       = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input logic                 CLK,
    input logic                 RST_N,
    coram_mem_arbiter_if.slave  bus
);
    localparam int unsigned W_O       = $clog2(N_REQ);
    localparam logic [3:0]  MAX_CNT   = 4'(MAX_BURST);

    typedef enum logic [0:0] {StIdle, StOwned} state_e;

    state_e           state_q, state_d;
    logic [W_O-1:0]   owner_q, owner_d;
    logic [W_O-1:0]   prio_q, prio_d;
    logic [3:0]       cnt_q, cnt_d;

    logic             gnt_valid;
    logic [W_O-1:0]   gnt_idx;
    logic             hold;
    logic             others;
    logic [W_O-1:0]   owner_next;
    int unsigned      start_idx;
    int unsigned      idx;
    logic [N_REQ-1:0] ack;

    logic             sel_we;
    logic [W_A-1:0]   sel_addr;
    logic [W_D-1:0]   sel_d;

    logic [W_A-1:0]   mem_addr_q;
    logic [W_D-1:0]   mem_d_q;
    logic             mem_we_q;
    logic [N_REQ-1:0] rd_pend_q;
    logic [N_REQ-1:0] rvalid_q;
    logic             busy_q;

    // Grant selection and arbiter next-state.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        prio_d     = prio_q;
        cnt_d      = cnt_q;
        gnt_valid  = 1'b0;
        gnt_idx    = '0;
        idx        = 0;
        owner_next = W_O'((int'(owner_q) + 1) % N_REQ);
        others     = |(bus.REQ & ~(N_REQ'(1) << owner_q));
        start_idx  = (state_q == StOwned) ? int'(owner_next) : int'(prio_q);

        // The owner keeps the port until its burst is spent, unless nobody else wants it.
        hold = (state_q == StOwned) && bus.REQ[owner_q] && ((cnt_q < MAX_CNT) || !others);

        if (hold) begin
            gnt_valid = 1'b1;
            gnt_idx   = owner_q;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = (start_idx + k) % N_REQ;
                if (!gnt_valid && bus.REQ[idx]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = W_O'(idx);
                end
            end
        end

        if (!gnt_valid) begin
            state_d = StIdle;
            cnt_d   = '0;
            if (state_q == StOwned) begin
                prio_d = owner_next;
            end
        end else if (hold) begin
            if (cnt_q < MAX_CNT) begin
                cnt_d = cnt_q + 4'd1;
            end
        end else begin
            state_d = StOwned;
            owner_d = gnt_idx;
            cnt_d   = 4'd1;
        end

        ack = gnt_valid ? (N_REQ'(1) << gnt_idx) : '0;
        if (!RST_N) begin
            ack = '0;
        end
    end

    // Mux the winning requester's access onto the memory port.
    always_comb begin
        sel_we   = bus.WE_IN[gnt_idx];
        sel_addr = bus.ADDR_IN[gnt_idx*W_A +: W_A];
        sel_d    = bus.D_IN[gnt_idx*W_D +: W_D];
    end

    // Arbiter state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StIdle;
            owner_q <= '0;
            prio_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory port, read-return pipeline (address stage, then data stage) and busy flag.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mem_addr_q <= '0;
            mem_d_q    <= '0;
            mem_we_q   <= 1'b0;
            rd_pend_q  <= '0;
            rvalid_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            mem_we_q  <= gnt_valid & sel_we;
            rd_pend_q <= (gnt_valid && !sel_we) ? ack : '0;
            rvalid_q  <= rd_pend_q;
            busy_q    <= gnt_valid;
            if (gnt_valid) begin
                mem_addr_q <= sel_addr;
                mem_d_q    <= sel_d;
            end
        end
    end

    assign bus.ACK      = ack;
    assign bus.RVALID   = rvalid_q;
    assign bus.RDATA    = bus.MEM_Q;
    assign bus.MEM_ADDR = mem_addr_q;
    assign bus.MEM_D    = mem_d_q;
    assign bus.MEM_WE   = mem_we_q;
    assign bus.BUSY     = busy_q;
endmodule

// File: tb/tb_coram_mem_arbiter.sv
// Directed bench for coram_mem_arbiter with a registered-read memory model.
module tb_coram_mem_arbiter;
    localparam int unsigned N_REQ     = 4;
    localparam int unsigned W_A       = 7;
    localparam int unsigned W_D       = 32;
    localparam int unsigned MAX_BURST = 4;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;

    always #5 CLK = ~CLK;

    coram_mem_arbiter_if #(.N_REQ(N_REQ), .W_A(W_A), .W_D(W_D)) bus ();

    coram_mem_arbiter #(
        .N_REQ    (N_REQ),
        .W_A      (W_A),
        .W_D      (W_D),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    // Single-port memory: write and read both registered, data one cycle after address.
    logic [W_D-1:0] mem [2**W_A];
    logic [W_D-1:0] mem_q;

    always @(posedge CLK) begin
        if (bus.MEM_WE) mem[bus.MEM_ADDR] <= bus.MEM_D;
        mem_q <= mem[bus.MEM_ADDR];
    end

    assign bus.MEM_Q = mem_q;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] we);
        bus.REQ   = req;
        bus.WE_IN = we;
        #1;
    endtask

    task automatic set_port(input int i, input logic [W_A-1:0] a, input logic [W_D-1:0] d);
        bus.ADDR_IN[i*W_A +: W_A] = a;
        bus.D_IN[i*W_D +: W_D]    = d;
    endtask

    logic [3:0] exp_ack;

    initial begin
        for (int i = 0; i < 2**W_A; i++) mem[i] = '0;
        mem[5] = 32'hDEADBEEF;
        mem_q = '0;
        bus.REQ = '0;
        bus.WE_IN = '0;
        bus.ADDR_IN = '0;
        bus.D_IN = '0;

        // Reset: grants masked even with all requesting, memory port cleared.
        RST_N = 1'b0;
        tick();
        drive(4'b1111, 4'b0000);
        check("rst_ack", 32'(bus.ACK), 32'h0);
        tick();
        check("rst_we", 32'(bus.MEM_WE), 32'h0);
        check("rst_addr", 32'(bus.MEM_ADDR), 32'h0);
        check("rst_d", bus.MEM_D, 32'h0);
        check("rst_rvalid", 32'(bus.RVALID), 32'h0);
        check("rst_busy", 32'(bus.BUSY), 32'h0);
        drive(4'b0000, 4'b0000);
        RST_N = 1'b1;
        tick();
        check("idle_ack", 32'(bus.ACK), 32'h0);

        // Single read from requester 0.
        set_port(0, 7'd5, 32'h0);
        drive(4'b0001, 4'b0000);
        check("rd0_ack", 32'(bus.ACK), 32'h1);
        tick();
        drive(4'b0000, 4'b0000);
        check("rd0_addr", 32'(bus.MEM_ADDR), 32'd5);
        check("rd0_we", 32'(bus.MEM_WE), 32'h0);
        check("rd0_busy", 32'(bus.BUSY), 32'h1);
        check("rd0_rv_early", 32'(bus.RVALID), 32'h0);
        tick();
        check("rd0_rvalid", 32'(bus.RVALID), 32'h1);
        check("rd0_rdata", bus.RDATA, 32'hDEADBEEF);
        tick();
        check("rd0_rv_off", 32'(bus.RVALID), 32'h0);
        check("rd0_busy_off", 32'(bus.BUSY), 32'h0);

        // Full contention after reset: four-grant bursts in order, writes every cycle.
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < N_REQ; i++) set_port(i, 7'(20 + i), 32'(i + 100));
        drive(4'b1111, 4'b1111);
        for (int i = 0; i < 17; i++) begin
            exp_ack = (i < 16) ? (4'b0001 << (i / 4)) : 4'b0001;
            check($sformatf("rr_ack%0d", i), 32'(bus.ACK), 32'(exp_ack));
            if (i > 0) check($sformatf("rr_we%0d", i), 32'(bus.MEM_WE), 32'h1);
            tick();
        end
        drive(4'b0000, 4'b0000);
        tick();

        // Lone requester is never forced off.
        drive(4'b0100, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("solo_ack%0d", i), 32'(bus.ACK), 32'h4);
            tick();
        end
        drive(4'b0000, 4'b0000);
        tick();
        tick();

        // Requester 1 writes addr 9, requester 3 reads it back right after.
        set_port(1, 7'd9, 32'h12345678);
        set_port(3, 7'd9, 32'h0);
        drive(4'b0010, 4'b0010);
        check("wr1_ack", 32'(bus.ACK), 32'h2);
        tick();
        drive(4'b1000, 4'b0000);
        check("rd3_ack", 32'(bus.ACK), 32'h8);
        check("wr1_we", 32'(bus.MEM_WE), 32'h1);
        check("wr1_addr", 32'(bus.MEM_ADDR), 32'd9);
        check("wr1_d", bus.MEM_D, 32'h12345678);
        tick();
        drive(4'b0000, 4'b0000);
        check("rd3_we", 32'(bus.MEM_WE), 32'h0);
        check("rd3_addr", 32'(bus.MEM_ADDR), 32'd9);
        check("wr1_no_rv", 32'(bus.RVALID), 32'h0);
        tick();
        check("rd3_rvalid", 32'(bus.RVALID), 32'h8);
        check("rd3_rdata", bus.RDATA, 32'h12345678);
        tick();

        // Reset right after a read: the return is dropped and priority restarts at 0.
        drive(4'b0001, 4'b0000);
        check("rst_rd_ack", 32'(bus.ACK), 32'h1);
        tick();
        drive(4'b0000, 4'b0000);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        check("rst_rd_rv0", 32'(bus.RVALID), 32'h0);
        check("rst_rd_we", 32'(bus.MEM_WE), 32'h0);
        drive(4'b1111, 4'b0000);
        check("rst_rd_gnt", 32'(bus.ACK), 32'h1);
        tick();
        drive(4'b0000, 4'b0000);
        check("rst_rd_rv1", 32'(bus.RVALID), 32'h0);
        tick();
        tick();

        // Owner drops mid-burst: grant moves over in the same cycle.
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        drive(4'b0011, 4'b0000);
        check("drop_ack0", 32'(bus.ACK), 32'h1);
        tick();
        check("drop_ack1", 32'(bus.ACK), 32'h1);
        tick();
        drive(4'b0010, 4'b0000);
        check("drop_ack2", 32'(bus.ACK), 32'h2);
        tick();
        check("drop_ack3", 32'(bus.ACK), 32'h2);
        check("drop_busy", 32'(bus.BUSY), 32'h1);
        tick();
        drive(4'b0000, 4'b0000);
        check("drop_idle", 32'(bus.ACK), 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
